uart_tx_cfg: RTL and testbench

Parametrised serial transmitter that replaces the fixed 8N1 UART transmitter in designs needing other frame formats or burst transmission. It accepts words through a small internal FIFO, frames each word with start bit, configurable data bits, optional parity and one or two stop bits, and drives a registered `tx` line toward the PC. Bit timing comes from an internal divisor counter, so no external baud generator is needed.

---
 rtl/uart_tx_cfg.sv | 152 +++++++++++++++
 tb/tb_uart_tx_cfg.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: small word FIFO feeding a framer that
// emits start, 5..9 data bits, optional parity and one or two stop bits.
module uart_tx_cfg #(
    parameter int CLK_DIV    = 434,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 ready,
    output logic                 busy,
    output logic                 drop
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PB = (PARITY != 0) ? 1 : 0;
    localparam int N  = 1 + DATA_BITS + PB + STOP_BITS;
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [AW:0]          r_count;

    logic [N-1:0]  r_frame;
    logic [CW-1:0] r_baud;
    logic [BW-1:0] r_bitc;
    logic          r_tx;
    logic          r_busy;
    logic          r_drop;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_tick;
    logic                 w_last;
    logic                 w_par;
    logic [DATA_BITS-1:0] w_head;
    logic [N-1:0]         w_frame;

    assign w_full  = (int'(r_count) == FIFO_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_push  = start & ~w_full;
    assign w_pop   = (r_state == S_LOAD);
    assign w_head  = r_mem[r_rptr];
    assign w_tick  = (r_state == S_SEND) && (int'(r_baud) == CLK_DIV - 1);
    assign w_last  = w_tick && (int'(r_bitc) == N - 1);
    assign w_par   = (PARITY == 2) ? ~(^w_head) : (^w_head);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= data;
        end
    end

    // Fullness is judged before this edge's pop, so a simultaneous pop
    // never rescues a push into a full FIFO.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_frame                = '1;
        w_frame[0]             = 1'b0;
        w_frame[DATA_BITS:1]   = w_head;
        if (PARITY != 0) begin
            w_frame[DATA_BITS+1] = w_par;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (!w_empty) w_next = S_LOAD;
            S_LOAD: w_next = S_SEND;
            S_SEND: begin
                if (w_last) begin
                    w_next = w_empty ? S_IDLE : S_LOAD;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_frame <= '1;
            r_baud  <= '0;
            r_bitc  <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tx    <= (r_state == S_SEND) ? r_frame[0] : 1'b1;
            r_busy  <= (r_count != '0) || (r_state != S_IDLE);
            r_drop  <= start & w_full;
            if (r_state == S_LOAD) begin
                r_frame <= w_frame;
                r_baud  <= '0;
                r_bitc  <= '0;
            end else if (r_state == S_SEND) begin
                if (w_tick) begin
                    r_baud  <= '0;
                    r_bitc  <= r_bitc + 1'b1;
                    r_frame <= {1'b1, r_frame[N-1:1]};
                end else begin
                    r_baud <= r_baud + 1'b1;
                end
            end
        end
    end

    assign tx    = r_tx;
    assign ready = ~w_full;
    assign busy  = r_busy;
    assign drop  = r_drop;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Four differently configured transmitters driven by shared stimulus and
// checked each cycle against a frame-schedule model of the line.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [8:0] data;
    logic [3:0] o_tx, o_rdy, o_busy, o_drop;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rstn(rstn), .start(start), .data(data[7:0]),
        .tx(o_tx[0]), .ready(o_rdy[0]), .busy(o_busy[0]), .drop(o_drop[0]));
    uart_tx_cfg #(.CLK_DIV(3), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rstn(rstn), .start(start), .data(data[6:0]),
        .tx(o_tx[1]), .ready(o_rdy[1]), .busy(o_busy[1]), .drop(o_drop[1]));
    uart_tx_cfg #(.CLK_DIV(2), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(2)) u2 (
        .clk(clk), .rstn(rstn), .start(start), .data(data[8:0]),
        .tx(o_tx[2]), .ready(o_rdy[2]), .busy(o_busy[2]), .drop(o_drop[2]));
    uart_tx_cfg #(.CLK_DIV(3), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rstn(rstn), .start(start), .data(data[6:0]),
        .tx(o_tx[3]), .ready(o_rdy[3]), .busy(o_busy[3]), .drop(o_drop[3]));

    function automatic int f_cd(int k);
        case (k) 0: return 4; 1: return 3; 2: return 2; default: return 3; endcase
    endfunction
    function automatic int f_db(int k);
        case (k) 0: return 8; 1: return 7; 2: return 9; default: return 7; endcase
    endfunction
    function automatic int f_par(int k);
        case (k) 1: return 1; 3: return 2; default: return 0; endcase
    endfunction
    function automatic int f_sb(int k);
        return (k == 0) ? 1 : 2;
    endfunction
    function automatic int f_dep(int k);
        return (k == 2) ? 2 : 4;
    endfunction
    function automatic int f_n(int k);
        return 1 + f_db(k) + ((f_par(k) != 0) ? 1 : 0) + f_sb(k);
    endfunction

    // Bit idx of the serial frame carrying word w.
    function automatic logic f_bit(int k, logic [8:0] w, int idx);
        logic p;
        if (idx == 0) return 1'b0;
        if (idx <= f_db(k)) return w[idx-1];
        if (f_par(k) != 0 && idx == f_db(k) + 1) begin
            p = 1'b0;
            for (int j = 0; j < f_db(k); j++) p ^= w[j];
            return (f_par(k) == 2) ? ~p : p;
        end
        return 1'b1;
    endfunction

    // Model: every accepted word gets a pop edge; its frame occupies the
    // edges pop+1 .. pop+N*CLK_DIV. Pop = max(push+2, previous frame end+1).
    int         cyc = 0;
    int         n [4];
    int         pop_e [4][1024];
    logic [8:0] wd [4][1024];
    logic [3:0] e_tx, e_rdy, e_busy, e_drop;
    int         vecs = 0;
    int         miss = 0;

    always @(posedge clk) begin
        int   cb, ca, nc, pe;
        logic act, full, txv;
        cyc = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            nc = f_n(k) * f_cd(k);
            if (!rstn) begin
                n[k] = 0;
                e_tx[k] = 1'b1; e_rdy[k] = 1'b1; e_busy[k] = 1'b0; e_drop[k] = 1'b0;
            end else begin
                cb = 0; act = 1'b0;
                for (int i = 0; i < n[k]; i++) begin
                    if (pop_e[k][i] > cyc - 1) cb++;
                    if (pop_e[k][i] <= cyc && cyc <= pop_e[k][i] + nc) act = 1'b1;
                end
                full = (cb == f_dep(k));
                e_busy[k] = (cb > 0) || act;
                e_drop[k] = start && full;
                if (start && !full && n[k] < 1024) begin
                    pe = cyc + 2;
                    if (n[k] > 0 && pop_e[k][n[k]-1] + nc + 1 > pe) pe = pop_e[k][n[k]-1] + nc + 1;
                    pop_e[k][n[k]] = pe;
                    wd[k][n[k]] = data & 9'((1 << f_db(k)) - 1);
                    n[k]++;
                end
                ca = 0; txv = 1'b1;
                for (int i = 0; i < n[k]; i++) begin
                    if (pop_e[k][i] > cyc) ca++;
                    if (pop_e[k][i] + 1 <= cyc && cyc <= pop_e[k][i] + nc)
                        txv = f_bit(k, wd[k][i], (cyc - pop_e[k][i] - 1) / f_cd(k));
                end
                e_rdy[k] = (ca < f_dep(k));
                e_tx[k] = txv;
            end
        end
    end

    task automatic cmp(string nm, int k, logic got, logic exp);
        vecs++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s[%0d] cycle %0d: got %b expected %b", nm, k, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int k = 0; k < 4; k++) begin
                cmp("tx", k, o_tx[k], e_tx[k]);
                cmp("ready", k, o_rdy[k], e_rdy[k]);
                cmp("busy", k, o_busy[k], e_busy[k]);
                cmp("drop", k, o_drop[k], e_drop[k]);
            end
        end
    end

    task automatic push(input logic [8:0] d, output int e);
        @(negedge clk);
        start = 1'b1; data = d; e = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_to(int x);
        while (cyc < x) @(negedge clk);
    endtask

    task automatic wait_idle(int lim);
        int t;
        t = 0;
        while (o_busy != 4'b0 && t < lim) begin
            @(negedge clk);
            t++;
        end
        if (t >= lim) begin
            vecs++; miss++;
            $display("FAIL idle_timeout cycle %0d: busy %b expected 0000", cyc, o_busy);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int         e, p;
        int         dens;
        logic [9:0] fa;
        rstn = 1'b0; start = 1'b0; data = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            cmp("rst_tx", k, o_tx[k], 1'b1);
            cmp("rst_ready", k, o_rdy[k], 1'b1);
            cmp("rst_busy", k, o_busy[k], 1'b0);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // 0xA5 on the 8N1 instance, CLK_DIV 4.
        fa = 10'b1101001010;
        push(9'h0A5, e);
        wait_to(e + 2); cmp("a5_pre", 0, o_tx[0], 1'b1);
        for (int j = 0; j < 10; j++) begin
            wait_to(e + 3 + 4 * j);     cmp("a5_bit", j, o_tx[0], fa[j]);
            wait_to(e + 3 + 4 * j + 3); cmp("a5_bitend", j, o_tx[0], fa[j]);
        end
        wait_to(e + 42); cmp("a5_busy_hi", 0, o_busy[0], 1'b1);
        wait_to(e + 43); cmp("a5_busy_lo", 0, o_busy[0], 1'b0);
        wait_idle(500);

        // 0x41, 7 data bits, even (u1) and odd (u3) parity, two stops.
        push(9'h041, e);
        wait_to(e + 3);      cmp("p_start", 1, o_tx[1], 1'b0); cmp("p_start", 3, o_tx[3], 1'b0);
        wait_to(e + 6);      cmp("p_d0", 1, o_tx[1], 1'b1);
        wait_to(e + 9);      cmp("p_d1", 1, o_tx[1], 1'b0);
        wait_to(e + 24);     cmp("p_d6", 1, o_tx[1], 1'b1);
        wait_to(e + 28);     cmp("p_even", 1, o_tx[1], 1'b0); cmp("p_odd", 3, o_tx[3], 1'b1);
        wait_to(e + 30);     cmp("p_stop1", 1, o_tx[1], 1'b1);
        wait_to(e + 33);     cmp("p_stop2", 3, o_tx[3], 1'b1);
        wait_idle(500);

        // Six pushes back to back: fifth fills the FIFO, sixth is dropped.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) e = cyc + 1;
            if (i == 5) begin
                cmp("burst_ready_lo", 0, o_rdy[0], 1'b0);
                cmp("burst_nodrop", 0, o_drop[0], 1'b0);
            end
            start = 1'b1; data = 9'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        cmp("burst_drop", 0, o_drop[0], 1'b1);
        wait_to(e + 6); cmp("burst_drop_end", 0, o_drop[0], 1'b0);
        wait_idle(2000);

        // Reset during data bit 3 of the first of three queued words.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) e = cyc + 1;
            start = 1'b1; data = 9'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        wait_to(e + 20);
        rstn = 1'b0;
        wait_to(e + 21);
        for (int k = 0; k < 4; k++) begin
            cmp("mid_rst_tx", k, o_tx[k], 1'b1);
            cmp("mid_rst_busy", k, o_busy[k], 1'b0);
        end
        rstn = 1'b1;
        repeat (300) @(negedge clk);
        cmp("post_rst_busy", 0, o_busy[0], 1'b0);

        // Push during the last stop bit: only the LOAD cycle separates frames.
        push(9'h03C, e);
        p = e + 2;
        wait_to(p + 37);
        push(9'h0C3, e);
        wait_to(p + 41); cmp("stop_push_gap", 0, o_tx[0], 1'b1);
        wait_to(p + 42); cmp("stop_push_start", 0, o_tx[0], 1'b0);
        wait_idle(500);

        // 0x1FF on the 9-bit, two-stop, CLK_DIV 2 instance.
        push(9'h1FF, e);
        wait_to(e + 3); cmp("w9_start", 2, o_tx[2], 1'b0);
        for (int j = 1; j < 12; j++) begin
            wait_to(e + 3 + 2 * j); cmp("w9_one", j, o_tx[2], 1'b1);
        end
        wait_to(e + 26); cmp("w9_busy_hi", 2, o_busy[2], 1'b1);
        wait_to(e + 27); cmp("w9_busy_lo", 2, o_busy[2], 1'b0);
        wait_idle(500);

        // Random traffic with varying density and rare resets.
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        dens = 20;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (c % 500 == 0) dens = $urandom_range(1, 60);
            rstn  = ($urandom_range(0, 999) != 0);
            start = ($urandom_range(0, 99) < dens);
            data  = 9'($urandom);
        end
        @(negedge clk);
        start = 1'b0; rstn = 1'b1;
        wait_idle(3000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
